// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-store loader.
//   load_state_t    : loader FSM states (IDLE, RECV_HI, RECV_LO, DONE)
//   DEPTH_DEFAULT   : default number of 16-bit words in the store
//   AW_DEFAULT      : default word-address width, log2(DEPTH_DEFAULT)
//   DEFAULT_PROG    : power-on program, also used by the core's testbench
//   default_word()  : returns the power-on word for any store index
package imem_loader_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int AW_DEFAULT    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV_HI = 2'd1,
        RECV_LO = 2'd2,
        DONE    = 2'd3
    } load_state_t;

    localparam logic [15:0] DEFAULT_PROG [16] = '{
        16'h8101, 16'h8202, 16'h0312, 16'h4423,
        16'h5534, 16'h2640, 16'h3751, 16'hC002,
        16'h9863, 16'hA974, 16'hBA85, 16'h6B96,
        16'h7CA7, 16'hDDB8, 16'hEEC9, 16'hF000
    };

    // The power-on program is 16 words long; a deeper store repeats it so
    // that every entry still resets to a known instruction.
    function automatic logic [15:0] default_word(input int idx);
        return DEFAULT_PROG[idx % 16];
    endfunction

endpackage

// File: rtl/imem_store.sv
// imem_store
// DEPTH x 16 writable instruction store with one synchronous write port and
// one combinational read port. Reset restores the power-on program.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   we        : write enable
//   wr_addr   : write word address
//   wr_data   : write data
//   rd_addr   : read word address (PC word index)
//   rd_data   : combinational read data, mem[rd_addr]
module imem_store
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [DEPTH];

    // Register array: reset reloads the default program into every entry, so a
    // reset in the middle of a load discards all of the partially loaded words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= default_word(i);
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read of the word being written returns the old contents until the edge.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Program-load stage for the 16-bit core. Receives a big-endian byte stream
// over valid/ready, assembles 16-bit words and writes them into the store.
// While a load is in progress, cpu_hold keeps the CPU in reset.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load_req    : level; a rising edge in IDLE starts a load, dropping it aborts
//   byte_in     : program byte
//   byte_valid  : byte_in is valid
//   byte_ready  : a byte can be accepted this cycle
//   rd_addr     : fetch word address (pc[4:1])
//   rd_instr    : combinational fetch data
//   cpu_hold    : high while not IDLE
//   load_done   : one-cycle pulse after the last word is written
//   load_abort  : one-cycle pulse while load_req is low in a receive state
//   csum        : XOR of all bytes accepted since the last load start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_instr,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_abort,
    output logic [7:0]    csum
);

    load_state_t   state;
    load_state_t   state_next;
    logic          req_q;
    logic [AW-1:0] word_ptr;
    logic [7:0]    hi_byte;
    logic          start_load;
    logic          accept_hi;
    logic          accept_lo;
    logic          last_word;

    assign last_word = (word_ptr == AW'(DEPTH - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. A low load_req in a receive state wins
    // over a byte offered in the same cycle: the byte is refused and the load
    // abandoned. load_req is not looked at in DONE, and since req_q tracks it
    // every cycle, a level still held high afterwards cannot restart a load.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        load_done  = 1'b0;
        load_abort = 1'b0;
        start_load = 1'b0;
        accept_hi  = 1'b0;
        accept_lo  = 1'b0;
        case (state)
            IDLE: begin
                if (load_req && !req_q) begin
                    start_load = 1'b1;
                    state_next = RECV_HI;
                end
            end
            RECV_HI: begin
                byte_ready = 1'b1;
                if (!load_req) begin
                    load_abort = 1'b1;
                    state_next = IDLE;
                end else if (byte_valid) begin
                    accept_hi  = 1'b1;
                    state_next = RECV_LO;
                end
            end
            RECV_LO: begin
                byte_ready = 1'b1;
                if (!load_req) begin
                    load_abort = 1'b1;
                    state_next = IDLE;
                end else if (byte_valid) begin
                    accept_lo  = 1'b1;
                    state_next = last_word ? DONE : RECV_HI;
                end
            end
            DONE: begin
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cpu_hold = (state != IDLE);

    // Datapath: load_req edge detector, high-byte latch, word pointer and the
    // running checksum. The pointer never wraps because the last word sends
    // the FSM to DONE instead of incrementing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= 1'b0;
            word_ptr <= '0;
            hi_byte  <= 8'h00;
            csum     <= 8'h00;
        end else begin
            req_q <= load_req;
            if (start_load) begin
                word_ptr <= '0;
                csum     <= 8'h00;
            end else if (accept_hi) begin
                hi_byte <= byte_in;
                csum    <= csum ^ byte_in;
            end else if (accept_lo) begin
                csum <= csum ^ byte_in;
                if (!last_word) begin
                    word_ptr <= word_ptr + AW'(1);
                end
            end
        end
    end

    imem_store #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .we      (accept_lo),
        .wr_addr (word_ptr),
        .wr_data ({hi_byte, byte_in}),
        .rd_addr (rd_addr),
        .rd_data (rd_instr)
    );

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader: a short table of hand-computed vectors,
// then randomized loads checked against a byte-counting reference model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [3:0]  rd_addr;
    logic [15:0] rd_instr;
    logic        cpu_hold;
    logic        load_done;
    logic        load_abort;
    logic [7:0]  csum;

    int n_compared;
    int n_mismatched;

    // Reference model: a load is just a count of accepted bytes.
    int          m_phase;     // 0 idle, 1 loading, 2 done pulse
    int          m_count;
    logic        m_req_prev;
    logic [7:0]  m_hi;
    logic [7:0]  m_csum;
    logic [15:0] m_mem [16];

    typedef struct {
        logic        req;
        logic [7:0]  b;
        logic        v;
        logic [3:0]  addr;
        logic        e_ready;
        logic        e_hold;
        logic        e_done;
        logic        e_abort;
        logic [15:0] e_rd;
        logic [7:0]  e_csum;
    } vec_t;

    vec_t tbl [7];

    imem_loader #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .rd_addr    (rd_addr),
        .rd_instr   (rd_instr),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_abort (load_abort),
        .csum       (csum)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic req, input logic [7:0] b, input logic v,
                                input logic [3:0] addr, input logic e_ready,
                                input logic e_hold, input logic e_done,
                                input logic e_abort, input logic [15:0] e_rd,
                                input logic [7:0] e_csum);
        vec_t r;
        r.req = req; r.b = b; r.v = v; r.addr = addr;
        r.e_ready = e_ready; r.e_hold = e_hold; r.e_done = e_done;
        r.e_abort = e_abort; r.e_rd = e_rd; r.e_csum = e_csum;
        return r;
    endfunction

    function automatic logic [7:0] pattern_byte(input int idx);
        return (idx % 2 == 0) ? 8'h10 : 8'(idx / 2);
    endfunction

    task automatic applyStimulus(input logic req, input logic [7:0] b,
                                 input logic v, input logic [3:0] addr);
        load_req   = req;
        byte_in    = b;
        byte_valid = v;
        rd_addr    = addr;
    endtask

    task automatic cmp1(input string tag, input string field, input logic [15:0] got,
                        input logic [15:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s.%s got %h want %h at %0t", tag, field, got, want, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic e_ready, input logic e_hold,
                               input logic e_done, input logic e_abort,
                               input logic [15:0] e_rd, input logic [7:0] e_csum);
        cmp1(tag, "byte_ready", 16'(byte_ready), 16'(e_ready));
        cmp1(tag, "cpu_hold",   16'(cpu_hold),   16'(e_hold));
        cmp1(tag, "load_done",  16'(load_done),  16'(e_done));
        cmp1(tag, "load_abort", 16'(load_abort), 16'(e_abort));
        cmp1(tag, "rd_instr",   rd_instr,        e_rd);
        cmp1(tag, "csum",       16'(csum),       16'(e_csum));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = DEFAULT_PROG[i];
        m_phase    = 0;
        m_count    = 0;
        m_req_prev = 1'b0;
        m_hi       = 8'h00;
        m_csum     = 8'h00;
    endtask

    // Advance the model across one rising edge using the inputs of that cycle.
    task automatic model_commit(input logic req, input logic [7:0] b, input logic v);
        case (m_phase)
            1: begin
                if (!req) begin
                    m_phase = 0;
                end else if (v) begin
                    m_csum ^= b;
                    if (m_count % 2 == 0) m_hi = b;
                    else m_mem[m_count / 2] = {m_hi, b};
                    m_count++;
                    if (m_count == 32) m_phase = 2;
                end
            end
            2: m_phase = 0;
            default: begin
                if (req && !m_req_prev) begin
                    m_phase = 1;
                    m_count = 0;
                    m_csum  = 8'h00;
                end
            end
        endcase
        m_req_prev = req;
    endtask

    // One clock cycle: drive just after the edge, check at the falling edge
    // against the model, then let the model follow the rising edge.
    task automatic run_cycle(input string tag, input logic req, input logic [7:0] b,
                             input logic v, input logic [3:0] addr);
        applyStimulus(req, b, v, addr);
        @(negedge clk);
        checkOutput(tag, m_phase == 1, m_phase != 0, m_phase == 2,
                    (m_phase == 1) && !req, m_mem[addr], m_csum);
        @(posedge clk);
        model_commit(req, b, v);
        #1;
    endtask

    // Start a load and feed nbytes accepted bytes; load_req is left high.
    task automatic load_bytes(input string tag, input int nbytes, input bit gapped,
                              input bit rand_data);
        int idx;
        int cycles;
        logic v;
        logic acc;
        logic [7:0] b;
        run_cycle(tag, 1'b0, 8'h00, 1'b0, 4'($urandom_range(0, 15)));
        run_cycle(tag, 1'b1, 8'h00, 1'b0, 4'($urandom_range(0, 15)));
        idx = 0;
        cycles = 0;
        while (idx < nbytes && cycles < 400) begin
            v   = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            b   = rand_data ? 8'($urandom_range(0, 255)) : pattern_byte(idx);
            acc = (m_phase == 1) && v;
            run_cycle(tag, 1'b1, b, v, 4'($urandom_range(0, 15)));
            if (acc) idx++;
            cycles++;
        end
        n_compared++;
        if (idx != nbytes) begin
            n_mismatched++;
            $display("[TB] FAIL %s.byte_budget got %0d want %0d", tag, idx, nbytes);
        end
    endtask

    task automatic sweep(input string tag, input logic req);
        for (int a = 0; a < 16; a++) run_cycle(tag, req, 8'h00, 1'b0, 4'(a));
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checkOutput(tag, 1'b0, 1'b0, 1'b0, 1'b0, DEFAULT_PROG[rd_addr], 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, rd_addr);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model_reset();

        // Hand-computed vectors starting from reset: start, one word, abort.
        tbl[0] = mk(1'b0, 8'h00, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, DEFAULT_PROG[15], 8'h00);
        tbl[1] = mk(1'b1, 8'h00, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, DEFAULT_PROG[0],  8'h00);
        tbl[2] = mk(1'b1, 8'hAB, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, DEFAULT_PROG[0],  8'h00);
        tbl[3] = mk(1'b1, 8'hCD, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, DEFAULT_PROG[0],  8'hAB);
        tbl[4] = mk(1'b1, 8'h00, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 16'hABCD,         8'h66);
        tbl[5] = mk(1'b0, 8'h12, 1'b1, 4'd1,  1'b1, 1'b1, 1'b0, 1'b1, DEFAULT_PROG[1],  8'h66);
        tbl[6] = mk(1'b0, 8'h34, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'hABCD,         8'h66);

        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 4'd15);
        #3;
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, DEFAULT_PROG[15], 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].req, tbl[i].b, tbl[i].v, tbl[i].addr);
            @(negedge clk);
            checkOutput($sformatf("table%0d", i), tbl[i].e_ready, tbl[i].e_hold,
                        tbl[i].e_done, tbl[i].e_abort, tbl[i].e_rd, tbl[i].e_csum);
            @(posedge clk);
            model_commit(tbl[i].req, tbl[i].b, tbl[i].v);
            #1;
        end

        $display("[TB] full load, valid held high");
        load_bytes("full", 32, 1'b0, 1'b0);
        run_cycle("full_done", 1'b1, 8'h00, 1'b1, 4'd15);
        run_cycle("full_idle", 1'b1, 8'h00, 1'b1, 4'd14);
        sweep("full_mem", 1'b1);
        for (int a = 0; a < 16; a++) begin
            cmp1("full_model", $sformatf("mem%0d", a), m_mem[a], 16'h1000 + 16'(a));
        end
        cmp1("full_model", "csum", 16'(m_csum), 16'h0000);

        $display("[TB] gapped load, random data");
        load_bytes("gap_rand", 32, 1'b1, 1'b1);
        run_cycle("gap_rand_done", 1'b1, 8'h00, 1'b0, 4'd0);
        sweep("gap_rand_mem", 1'b1);

        $display("[TB] gapped load, pattern data");
        load_bytes("gap_pat", 32, 1'b1, 1'b0);
        run_cycle("gap_pat_done", 1'b1, 8'h00, 1'b0, 4'd0);
        sweep("gap_pat_mem", 1'b1);

        $display("[TB] abort after 5 bytes");
        do_reset("reset_pre_abort");
        load_bytes("abort", 5, 1'b0, 1'b1);
        run_cycle("abort_drop", 1'b0, 8'h77, 1'b1, 4'd2);
        sweep("abort_mem", 1'b0);

        $display("[TB] abort priority at word 3 low byte");
        load_bytes("prio", 7, 1'b1, 1'b1);
        run_cycle("prio_drop", 1'b0, 8'h5A, 1'b1, 4'd3);
        run_cycle("prio_after", 1'b0, 8'h00, 1'b0, 4'd3);
        sweep("prio_mem", 1'b0);

        $display("[TB] reset mid-load");
        load_bytes("midrst", 10, 1'b0, 1'b1);
        do_reset("midrst_async");
        sweep("midrst_mem", 1'b0);
        load_bytes("reload", 2, 1'b0, 1'b1);
        run_cycle("reload_w0", 1'b0, 8'h00, 1'b0, 4'd0);
        sweep("reload_mem", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
